// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
`timescale 1ns/1ps
package imem_pkg;
    localparam int MEM_LAT_MAX = 8;
    localparam int CNT_W       = 4;

    typedef enum logic {OWN_F = 1'b0, OWN_L = 1'b1} owner_e;
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;
endpackage

// File: rtl/imem_lat_counter.sv
// Loadable down-counter with zero flag; counts the memory latency of the outstanding access.
`timescale 1ns/1ps
module lat_counter
    import imem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/imem_arbiter.sv
// Serialises fetch and loader accesses onto the single-port instruction memory.
// Define IMEM_ARB_RR_EN for round-robin arbitration; default is loader-over-fetch priority.
`timescale 1ns/1ps
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          f_flush,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_done,
    output logic [31:0]   l_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);
    state_e        state_q, state_d;
    owner_e        own_q, own_d;
    logic          kill_q, kill_d;
    logic          f_gnt_q, f_gnt_d;
    logic          f_rvalid_q, f_rvalid_d;
    logic [31:0]   f_rdata_q, f_rdata_d;
    logic          l_gnt_q, l_gnt_d;
    logic          l_done_q, l_done_d;
    logic [31:0]   l_rdata_q, l_rdata_d;
    logic          m_en_q, m_en_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          cnt_load, cnt_dec, cnt_zero;
    owner_e        win;
`ifdef IMEM_ARB_RR_EN
    owner_e        ptr_q, ptr_d;
`endif

    lat_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(MEM_LAT)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        win = OWN_F;
`ifdef IMEM_ARB_RR_EN
        // Pointer holds the last granted requester; on contention the other one wins.
        if (l_req && f_req) begin
            win = (ptr_q == OWN_L) ? OWN_F : OWN_L;
        end else if (l_req) begin
            win = OWN_L;
        end
`else
        if (l_req) begin
            win = OWN_L;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        kill_d     = kill_q;
        f_gnt_d    = 1'b0;
        f_rvalid_d = 1'b0;
        f_rdata_d  = f_rdata_q;
        l_gnt_d    = 1'b0;
        l_done_d   = 1'b0;
        l_rdata_d  = l_rdata_q;
        m_en_d     = 1'b0;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
`ifdef IMEM_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (f_req || l_req) begin
                    state_d  = S_BUSY;
                    own_d    = win;
                    cnt_load = 1'b1;
                    m_en_d   = 1'b1;
`ifdef IMEM_ARB_RR_EN
                    ptr_d    = win;
`endif
                    if (win == OWN_L) begin
                        m_we_d    = l_we;
                        m_addr_d  = l_addr;
                        m_wdata_d = l_wdata;
                        l_gnt_d   = 1'b1;
                    end else begin
                        m_we_d    = 1'b0;
                        m_addr_d  = f_addr;
                        m_wdata_d = '0;
                        f_gnt_d   = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if ((own_q == OWN_F) && f_flush) begin
                    kill_d = 1'b1;
                end
                if (cnt_zero) begin
                    state_d = S_IDLE;
                    kill_d  = 1'b0;
                    if (own_q == OWN_L) begin
                        l_done_d  = 1'b1;
                        l_rdata_d = m_we_q ? 32'h0 : m_rdata;
                    end else if (!(kill_q || f_flush)) begin
                        // A flush in the completion cycle itself also discards the word.
                        f_rvalid_d = 1'b1;
                        f_rdata_d  = m_rdata;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            own_q      <= OWN_F;
            kill_q     <= 1'b0;
            f_gnt_q    <= 1'b0;
            f_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            l_gnt_q    <= 1'b0;
            l_done_q   <= 1'b0;
            l_rdata_q  <= '0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
`ifdef IMEM_ARB_RR_EN
            ptr_q      <= OWN_F;
`endif
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            kill_q     <= kill_d;
            f_gnt_q    <= f_gnt_d;
            f_rvalid_q <= f_rvalid_d;
            f_rdata_q  <= f_rdata_d;
            l_gnt_q    <= l_gnt_d;
            l_done_q   <= l_done_d;
            l_rdata_q  <= l_rdata_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
`ifdef IMEM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign f_gnt    = f_gnt_q;
    assign f_rvalid = f_rvalid_q;
    assign f_rdata  = f_rdata_q;
    assign l_gnt    = l_gnt_q;
    assign l_done   = l_done_q;
    assign l_rdata  = l_rdata_q;
    assign m_en     = m_en_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a latency-accurate memory model (MEM_LAT = 2).
`timescale 1ns/1ps
module tb_imem_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_flush, f_gnt, f_rvalid;
    logic [31:0] f_addr, f_rdata;
    logic        l_req, l_we, l_gnt, l_done;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [133:0] outs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.MEM_LAT(LAT), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    assign outs = {f_gnt, f_rvalid, f_rdata, l_gnt, l_done, l_rdata,
                   m_en, m_we, m_addr, m_wdata};

    // Memory model: unwritten words read as a fixed pattern; data is driven only in cycle issue+LAT.
    logic [31:0]    mem [0:63];
    logic [63:0]    written = '0;
    logic [LAT-1:0] vpipe   = '0;
    logic [31:0]    dpipe [0:LAT-1];

    function automatic logic [31:0] rd_word(input int idx);
        if (written[idx]) return mem[idx];
        if (idx == 1) return 32'h0010_0093;
        return 32'h1000_0000 + 32'(idx);
    endfunction

    always @(posedge clk) begin
        if (m_en && m_we) begin
            mem[int'(m_addr[7:2])]     <= m_wdata;
            written[int'(m_addr[7:2])] <= 1'b1;
        end
        vpipe[0] <= m_en;
        dpipe[0] <= rd_word(int'(m_addr[7:2]));
        for (int i = 1; i < LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
            dpipe[i] <= dpipe[i-1];
        end
    end

    assign m_rdata = vpipe[LAT-1] ? dpipe[LAT-1] : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_l;
        logic seen;
        rst = 1'b0; f_req = 1'b0; f_addr = '0; f_flush = 1'b0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs, 0);
        rst = 1'b1;
        tick();

        // Fetch of 0x4
        f_req = 1'b1; f_addr = 32'h4;
        tick();
        chk("f_gnt_issue", f_gnt, 1);
        chk("f_m_en", m_en, 1);
        chk("f_m_addr", m_addr, 32'h4);
        chk("f_m_we", m_we, 0);
        chk("f_no_l_gnt", l_gnt, 0);
        f_req = 1'b0;
        tick();
        chk("f_gnt_m_en_pulse", {f_gnt, m_en}, 0);
        repeat (LAT-1) tick();
        chk("f_rvalid_early", f_rvalid, 0);
        tick();
        chk("f_rvalid", f_rvalid, 1);
        chk("f_rdata", f_rdata, 32'h0010_0093);
        chk("f_l_quiet", {l_gnt, l_done, l_rdata}, 0);
        tick();
        chk("f_rvalid_pulse", f_rvalid, 0);

        // Loader write then read at 0x20, back-to-back at minimum spacing
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'hDEAD_BEEF;
        tick();
        chk("lw_gnt", l_gnt, 1);
        chk("lw_m_we", m_we, 1);
        chk("lw_m_addr", m_addr, 32'h20);
        chk("lw_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("lw_no_f_gnt", f_gnt, 0);
        l_req = 1'b0;
        repeat (LAT) tick();
        chk("lw_done_early", l_done, 0);
        tick();
        chk("lw_done", l_done, 1);
        chk("lw_rdata_zero", l_rdata, 0);
        l_req = 1'b1; l_we = 1'b0;
        tick();
        chk("lr_gnt_throughput", l_gnt, 1);
        chk("lr_m_we", m_we, 0);
        l_req = 1'b0;
        repeat (LAT) tick();
        tick();
        chk("lr_done", l_done, 1);
        chk("lr_rdata", l_rdata, 32'hDEAD_BEEF);

        // Contention for four transactions, starting from a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        f_addr = 32'h4; l_addr = 32'h20; l_we = 1'b0;
        f_req = 1'b1; l_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef IMEM_ARB_RR_EN
            exp_l = ((k % 2) == 0);
`else
            exp_l = 1'b1;
`endif
            tick();
            chk("arb_l_gnt", l_gnt, exp_l);
            chk("arb_f_gnt", f_gnt, !exp_l);
            if (k == 3) begin
                f_req = 1'b0; l_req = 1'b0;
            end
            repeat (LAT) tick();
            tick();
            if (exp_l) begin
                chk("arb_l_done", {l_done, f_rvalid}, 2'b10);
                chk("arb_l_rdata", l_rdata, 32'hDEAD_BEEF);
            end else begin
                chk("arb_f_rvalid", {f_rvalid, l_done}, 2'b10);
                chk("arb_f_rdata", f_rdata, 32'h0010_0093);
            end
        end

        // Flush: prime f_rdata, flush a fetch, then a normal fetch
        f_req = 1'b1; f_addr = 32'h8;
        tick();
        f_req = 1'b0;
        repeat (LAT) tick();
        tick();
        chk("pre_f_rvalid", f_rvalid, 1);
        chk("pre_f_rdata", f_rdata, 32'h1000_0002);
        f_req = 1'b1; f_addr = 32'hC;
        tick();
        chk("fl_gnt", f_gnt, 1);
        f_req = 1'b0;
        tick();
        f_flush = 1'b1;
        tick();
        f_flush = 1'b0;
        repeat (LAT-1) tick();
        chk("fl_no_rvalid", f_rvalid, 0);
        chk("fl_rdata_kept", f_rdata, 32'h1000_0002);
        f_req = 1'b1; f_addr = 32'h10;
        tick();
        chk("post_fl_gnt", f_gnt, 1);
        f_req = 1'b0;
        repeat (LAT) tick();
        tick();
        chk("post_fl_rvalid", f_rvalid, 1);
        chk("post_fl_rdata", f_rdata, 32'h1000_0004);

        // Flush while the loader owns the memory
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h24;
        tick();
        l_req = 1'b0;
        f_flush = 1'b1;
        repeat (LAT) tick();
        tick();
        f_flush = 1'b0;
        chk("ldfl_done", l_done, 1);
        chk("ldfl_rdata", l_rdata, 32'h1000_0009);
        chk("ldfl_no_f_rvalid", f_rvalid, 0);

        // Reset in the middle of a fetch
        f_req = 1'b1; f_addr = 32'h4;
        tick();
        chk("rs_gnt", f_gnt, 1);
        f_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rs_outs_async", outs, 0);
        tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (LAT + 2) begin
            tick();
            if (f_rvalid || f_gnt || l_done || m_en) seen = 1'b1;
        end
        chk("rs_no_stale_pulse", seen, 0);
        f_req = 1'b1; f_addr = 32'h10;
        tick();
        chk("rs_fresh_gnt", f_gnt, 1);
        f_req = 1'b0;
        repeat (LAT) tick();
        tick();
        chk("rs_fresh_rvalid", f_rvalid, 1);
        chk("rs_fresh_rdata", f_rdata, 32'h1000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
